// File: rtl/mem_arb_pkg.sv
// Shared encodings for the two-port memory arbiter: FSM states and requester ids.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_e;

    typedef enum logic {
        PORT_I = 1'b0,
        PORT_D = 1'b1
    } port_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of requester handshakes and memory-side signals around the arbiter.
// slave is the arbiter's view; master is the requesters-plus-memory view.
interface mem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_done;
    logic [DATA_W-1:0] i_rdata;
    logic              i_hit;
    logic              i_err;

    logic              d_req;
    logic              d_wr;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_done;
    logic [DATA_W-1:0] d_rdata;
    logic              d_hit;
    logic              d_err;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_rd;
    logic              mem_wr;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_done;
    logic              mem_hit;
    logic              mem_err;

    modport slave (
        input  i_req, i_addr, d_req, d_wr, d_addr, d_wdata,
               mem_rdata, mem_done, mem_hit, mem_err,
        output i_done, i_rdata, i_hit, i_err,
               d_done, d_rdata, d_hit, d_err,
               mem_addr, mem_wdata, mem_rd, mem_wr
    );

    modport master (
        output i_req, i_addr, d_req, d_wr, d_addr, d_wdata,
               mem_rdata, mem_done, mem_hit, mem_err,
        input  i_done, i_rdata, i_hit, i_err,
               d_done, d_rdata, d_hit, d_err,
               mem_addr, mem_wdata, mem_rd, mem_wr
    );

endinterface

// File: rtl/mem_arbiter_rr_pick2.sv
// Two-way round-robin pick: a lone request wins; on a tie the port
// opposite the previous grant wins.
module rr_pick2
    import mem_arb_pkg::*;
(
    input  logic  i_req_i,
    input  logic  d_req_i,
    input  port_e last_i,
    output port_e gnt_id_o,
    output logic  gnt_vld_o
);

    always_comb begin
        gnt_vld_o = i_req_i | d_req_i;
        gnt_id_o  = PORT_I;
        if (i_req_i && d_req_i) begin
            gnt_id_o = (last_i == PORT_D) ? PORT_I : PORT_D;
        end else if (d_req_i) begin
            gnt_id_o = PORT_D;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one cached memory between fetch and data requesters: latches the
// winner, pulses Rd/Wr once, waits for Done and returns a registered response.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);

    arb_state_e        state_q, state_d;
    port_e             last_q, last_d;
    port_e             port_q, port_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              wr_q, wr_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              hit_q, hit_d;
    logic              err_q, err_d;

    port_e             gnt_id;
    logic              gnt_vld;
    logic              busy, resp_i, resp_d;

    rr_pick2 u_pick (
        .i_req_i   (bus.i_req),
        .d_req_i   (bus.d_req),
        .last_i    (last_q),
        .gnt_id_o  (gnt_id),
        .gnt_vld_o (gnt_vld)
    );

    // Only control state is reset; latched data is qualified by state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= PORT_D;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
        port_q  <= port_d;
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
        wr_q    <= wr_d;
        rdata_q <= rdata_d;
        hit_q   <= hit_d;
        err_q   <= err_d;
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        port_d  = port_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wr_d    = wr_q;
        rdata_d = rdata_q;
        hit_d   = hit_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (gnt_vld) begin
                    port_d = gnt_id;
                    last_d = gnt_id;
                    if (gnt_id == PORT_D) begin
                        addr_d  = bus.d_addr;
                        wdata_d = bus.d_wdata;
                        wr_d    = bus.d_wr;
                    end else begin
                        addr_d  = bus.i_addr;
                        wdata_d = '0;
                        wr_d    = 1'b0;
                    end
                    // Odd addresses are rejected without touching the memory.
                    if (addr_d[0]) begin
                        err_d   = 1'b1;
                        hit_d   = 1'b0;
                        rdata_d = '0;
                        state_d = RESP;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (bus.mem_done) begin
                    rdata_d = wr_q ? '0 : bus.mem_rdata;
                    hit_d   = bus.mem_hit;
                    err_d   = bus.mem_err;
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy          = (state_q != IDLE);
        resp_i        = (state_q == RESP) && (port_q == PORT_I);
        resp_d        = (state_q == RESP) && (port_q == PORT_D);
        bus.mem_addr  = busy ? addr_q : '0;
        bus.mem_wdata = busy ? wdata_q : '0;
        bus.mem_rd    = (state_q == ISSUE) && !wr_q;
        bus.mem_wr    = (state_q == ISSUE) && wr_q;
        bus.i_done    = resp_i;
        bus.i_rdata   = resp_i ? rdata_q : '0;
        bus.i_hit     = resp_i && hit_q;
        bus.i_err     = resp_i && err_q;
        bus.d_done    = resp_d;
        bus.d_rdata   = resp_d ? rdata_q : '0;
        bus.d_hit     = resp_d && hit_q;
        bus.d_err     = resp_d && err_q;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small latency-programmable memory responder.
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

    mem_arbiter #(.ADDR_W(16), .DATA_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    // Memory responder: mem_done is high during the lat_cfg-th cycle after the Rd/Wr cycle.
    int          lat_cfg    = 1;
    logic [15:0] rd_cfg     = 16'h0000;
    logic        hit_cfg    = 1'b0;
    logic        err_cfg    = 1'b0;
    logic        force_done = 1'b0;
    int          cnt        = 0;
    logic        done_r     = 1'b0;

    assign bus.mem_rdata = rd_cfg;
    assign bus.mem_hit   = hit_cfg;
    assign bus.mem_err   = err_cfg;
    assign bus.mem_done  = done_r | force_done;

    always @(posedge clk) begin
        if (rst) begin
            cnt    <= 0;
            done_r <= 1'b0;
        end else if (bus.mem_rd || bus.mem_wr) begin
            cnt    <= 1;
            done_r <= (lat_cfg == 1);
        end else if (done_r) begin
            cnt    <= 0;
            done_r <= 1'b0;
        end else if (cnt != 0) begin
            cnt    <= cnt + 1;
            done_r <= ((cnt + 1) == lat_cfg);
        end
    end

    int pulses = 0;
    always @(negedge clk) begin
        if (bus.mem_rd || bus.mem_wr) pulses <= pulses + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input bit on_d, input int limit, output int cyc);
        cyc = -1;
        for (int k = 1; k <= limit; k++) begin
            step();
            if ((on_d && bus.d_done) || (!on_d && bus.i_done)) begin
                cyc = k;
                break;
            end
        end
    endtask

    initial begin
        int       cyc, snap, ni, nd, nord, last_cyc;
        logic [5:0] order;
        logic     seen;

        bus.i_req = 1'b0; bus.i_addr = '0;
        bus.d_req = 1'b0; bus.d_wr = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
        repeat (3) step();
        rst = 1'b0;

        check("rst_i",   64'({bus.i_done, bus.i_rdata, bus.i_hit, bus.i_err}), 64'd0);
        check("rst_d",   64'({bus.d_done, bus.d_rdata, bus.d_hit, bus.d_err}), 64'd0);
        check("rst_mem", 64'({bus.mem_addr, bus.mem_wdata, bus.mem_rd, bus.mem_wr}), 64'd0);

        // Fetch hit
        lat_cfg = 1; rd_cfg = 16'hBEEF; hit_cfg = 1'b1; err_cfg = 1'b0;
        bus.i_req = 1'b1; bus.i_addr = 16'h0010;
        step();
        check("fh_t1_rd",   64'({bus.mem_rd, bus.mem_wr}), 64'h2);
        check("fh_t1_addr", 64'(bus.mem_addr), 64'h0010);
        step();
        check("fh_t2_rd",   64'({bus.mem_rd, bus.mem_wr, bus.mem_done}), 64'h1);
        step();
        check("fh_t3_done", 64'({bus.i_done, bus.i_rdata, bus.i_hit, bus.i_err}), 64'({1'b1, 16'hBEEF, 1'b1, 1'b0}));
        check("fh_t3_ddone", 64'(bus.d_done), 64'd0);
        bus.i_req = 1'b0;
        step();
        check("fh_t4_idle", 64'({bus.i_done, bus.mem_addr}), 64'd0);

        // Store miss, 20-cycle memory latency
        lat_cfg = 20; rd_cfg = 16'hAAAA; hit_cfg = 1'b0;
        bus.d_req = 1'b1; bus.d_wr = 1'b1; bus.d_addr = 16'h0400; bus.d_wdata = 16'h1234;
        step();
        check("sm_t1_wr", 64'({bus.mem_rd, bus.mem_wr}), 64'h1);
        step();
        for (int k = 1; k <= 20; k++) begin
            check("sm_hold", 64'({bus.mem_addr, bus.mem_wdata, bus.mem_rd, bus.mem_wr, bus.d_done, bus.mem_done}),
                  64'({16'h0400, 16'h1234, 1'b0, 1'b0, 1'b0, (k == 20)}));
            step();
        end
        check("sm_resp", 64'({bus.d_done, bus.d_rdata, bus.d_hit, bus.d_err, bus.i_done}), 64'({1'b1, 16'h0000, 1'b0, 1'b0, 1'b0}));
        bus.d_req = 1'b0; bus.d_wr = 1'b0; bus.d_wdata = '0;
        step();

        // Simultaneous requests after reset: fetch wins the first tie
        rst = 1'b1;
        step();
        rst = 1'b0;
        lat_cfg = 1; rd_cfg = 16'h1111; hit_cfg = 1'b1;
        bus.i_addr = 16'h0020; bus.d_addr = 16'h0040;
        bus.i_req = 1'b1; bus.d_req = 1'b1;
        ni = 0; nd = 0; nord = 0; last_cyc = 0; order = '0; seen = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            step();
            if (bus.i_done && bus.d_done) seen = 1'b1;
            if (bus.i_done) begin
                order = {order[4:0], 1'b0}; nord++; ni++; last_cyc = c;
                if (ni == 3) bus.i_req = 1'b0;
            end
            if (bus.d_done) begin
                order = {order[4:0], 1'b1}; nord++; nd++; last_cyc = c;
                if (nd == 3) bus.d_req = 1'b0;
            end
        end
        check("rr_order", 64'(order), 64'h15);
        check("rr_count", 64'(nord), 64'd6);
        check("rr_both",  64'(seen), 64'd0);
        check("rr_last",  64'(last_cyc), 64'd23);

        // Misaligned data load
        rd_cfg = 16'h7777; hit_cfg = 1'b1;
        snap = pulses;
        bus.d_req = 1'b1; bus.d_wr = 1'b0; bus.d_addr = 16'h0003;
        step();
        check("mis_resp", 64'({bus.d_done, bus.d_rdata, bus.d_hit, bus.d_err, bus.mem_rd, bus.mem_wr}),
              64'({1'b1, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0}));
        bus.d_req = 1'b0;
        step();
        step();
        check("mis_after", 64'(bus.d_done), 64'd0);
        check("mis_pulses", 64'(pulses - snap), 64'd0);

        // Reset during WAIT
        lat_cfg = 10;
        bus.i_req = 1'b1; bus.i_addr = 16'h0050;
        step();
        step();
        step();
        check("rs_in_wait", 64'(bus.mem_addr), 64'h0050);
        rst = 1'b1; bus.i_req = 1'b0;
        step();
        rst = 1'b0;
        check("rs_i",   64'({bus.i_done, bus.i_rdata, bus.i_hit, bus.i_err}), 64'd0);
        check("rs_d",   64'({bus.d_done, bus.d_rdata, bus.d_hit, bus.d_err}), 64'd0);
        check("rs_mem", 64'({bus.mem_addr, bus.mem_wdata, bus.mem_rd, bus.mem_wr}), 64'd0);
        seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (bus.i_done || bus.d_done || bus.mem_rd || bus.mem_wr) seen = 1'b1;
        end
        check("rs_quiet", 64'(seen), 64'd0);
        lat_cfg = 3; rd_cfg = 16'h5A5A; hit_cfg = 1'b1;
        bus.i_req = 1'b1; bus.i_addr = 16'h0060;
        wait_done(1'b0, 10, cyc);
        check("rs_fetch_lat", 64'(cyc), 64'd5);
        check("rs_fetch_data", 64'({bus.i_rdata, bus.i_hit, bus.i_err}), 64'({16'h5A5A, 1'b1, 1'b0}));
        bus.i_req = 1'b0;
        step();

        // mem_done while IDLE is ignored
        force_done = 1'b1;
        step();
        force_done = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            if (bus.i_done || bus.d_done || bus.mem_rd || bus.mem_wr) seen = 1'b1;
        end
        check("stray_done", 64'(seen), 64'd0);

        // Memory error with request dropped during WAIT
        lat_cfg = 5; rd_cfg = 16'h0F0F; hit_cfg = 1'b0; err_cfg = 1'b1;
        bus.d_req = 1'b1; bus.d_wr = 1'b0; bus.d_addr = 16'h0100;
        step();
        step();
        bus.d_req = 1'b0;
        wait_done(1'b1, 10, cyc);
        check("er_lat",  64'(cyc), 64'd5);
        check("er_resp", 64'({bus.d_rdata, bus.d_hit, bus.d_err, bus.i_done}), 64'({16'h0F0F, 1'b0, 1'b1, 1'b0}));
        step();
        snap = pulses;
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (bus.d_done || bus.mem_rd || bus.mem_wr) seen = 1'b1;
            step();
        end
        check("er_noreissue", 64'(seen), 64'd0);
        check("er_pulses", 64'(pulses - snap), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
